// File: rtl/g729_pcm_pkg.sv
// Shared types and constants for the G729 PCM write-domain packer.
package g729_pcm_pkg;

    typedef enum logic [1:0] {
        StWaitSof,
        StLo,
        StHi,
        StDrop
    } pcm_state_e;

    localparam logic [15:0] HDR_MAGIC = 16'hA729;

    localparam int unsigned FRAME_LEN_DEFAULT = 80;

endpackage

// File: rtl/pcm_word_stage.sv
// Single-entry output register feeding the async FIFO write port.
// busy flags a held word that cannot drain this cycle, so a new load must be refused.
module pcm_word_stage #(
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk_wr,
    input  logic                  rst_wr_n,
    input  logic                  srst_wr_n,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] load_data,
    input  logic                  fifo_full,
    output logic                  busy,
    output logic                  fifo_wr_en,
    output logic [WORD_WIDTH-1:0] fifo_wr_data
);

    logic                  out_vld_q, out_vld_d;
    logic [WORD_WIDTH-1:0] out_data_q, out_data_d;

    // The FIFO RAM write enable is ungated, so never strobe while full or in sync reset.
    assign fifo_wr_en   = out_vld_q & ~fifo_full & srst_wr_n;
    assign busy         = out_vld_q & fifo_full;
    assign fifo_wr_data = out_data_q;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (load) begin
            out_vld_d  = 1'b1;
            out_data_d = load_data;
        end else if (fifo_wr_en) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else if (!srst_wr_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: rtl/pcm_frame_packer.sv
// Packs PCM sample pairs into FIFO words aligned to G729 frames, dropping whole frames
// on back-pressure. Optional frame header word enabled by PCM_PACKER_FRAME_HDR_EN.
module pcm_frame_packer
    import g729_pcm_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned FRAME_LEN    = FRAME_LEN_DEFAULT,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                      clk_wr,
    input  logic                      rst_wr_n,
    input  logic                      srst_wr_n,
    input  logic                      enable,
    input  logic                      sample_vld,
    input  logic                      sample_sof,
    input  logic [SAMPLE_WIDTH-1:0]   sample_data,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [2*SAMPLE_WIDTH-1:0] fifo_wr_data,
    output logic [CNT_WIDTH-1:0]      frame_cnt,
    output logic [CNT_WIDTH-1:0]      drop_cnt,
    output logic                      overflow
);

    localparam int unsigned WORD_WIDTH = 2 * SAMPLE_WIDTH;
    localparam int unsigned IDX_WIDTH  = $clog2(FRAME_LEN);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);

`ifdef PCM_PACKER_FRAME_HDR_EN
    localparam bit HdrEn = 1'b1;
`else
    localparam bit HdrEn = 1'b0;
`endif

    pcm_state_e state_q, state_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic [SAMPLE_WIDTH-1:0] lo_q, lo_d;
    logic [CNT_WIDTH-1:0]    frame_cnt_q, drop_cnt_q;
    logic                    overflow_q;

    logic                  busy;
    logic                  hdr_block;
    logic                  load;
    logic [WORD_WIDTH-1:0] load_data;
    logic [WORD_WIDTH-1:0] hdr_word;
    logic [15:0]           cnt16;
    logic                  frame_done;
    logic                  drop_ev;

    assign cnt16     = 16'(frame_cnt_q);
    assign hdr_word  = WORD_WIDTH'({HDR_MAGIC, cnt16});
    assign hdr_block = HdrEn & busy;

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_q <= StWaitSof;
            idx_q   <= '0;
            lo_q    <= '0;
        end else if (!srst_wr_n) begin
            state_q <= StWaitSof;
            idx_q   <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
        end
    end

    // Any valid SOF restarts packing; DROP and WAIT_SOF differ only in how they were entered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        if (sample_vld && sample_sof) begin
            if (enable) begin
                lo_d    = sample_data;
                idx_d   = IDX_WIDTH'(1);
                state_d = hdr_block ? StDrop : StHi;
            end else begin
                state_d = StWaitSof;
            end
        end else if (sample_vld) begin
            case (state_q)
                StLo: begin
                    lo_d    = sample_data;
                    idx_d   = idx_q + 1'b1;
                    state_d = StHi;
                end
                StHi: begin
                    if (busy) begin
                        state_d = StDrop;
                    end else if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = StWaitSof;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StLo;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        load       = 1'b0;
        load_data  = hdr_word;
        frame_done = 1'b0;
        drop_ev    = 1'b0;
        if (sample_vld && sample_sof) begin
            // An SOF inside a frame abandons the partial frame.
            drop_ev = (state_q == StLo) || (state_q == StHi);
            if (enable) begin
                if (hdr_block) begin
                    drop_ev = 1'b1;
                end
                load = HdrEn & ~busy;
            end
        end else if (sample_vld && (state_q == StHi)) begin
            if (busy) begin
                drop_ev = 1'b1;
            end else begin
                load       = 1'b1;
                load_data  = {sample_data, lo_q};
                frame_done = (idx_q == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else if (!srst_wr_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(frame_done);
            drop_cnt_q  <= drop_cnt_q + CNT_WIDTH'(drop_ev);
            overflow_q  <= drop_ev;
        end
    end

    pcm_word_stage #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_word_stage (
        .clk_wr       (clk_wr),
        .rst_wr_n     (rst_wr_n),
        .srst_wr_n    (srst_wr_n),
        .load         (load),
        .load_data    (load_data),
        .fifo_full    (fifo_full),
        .busy         (busy),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data)
    );

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Scoreboard bench for pcm_frame_packer: a frame-level queue model predicts FIFO words,
// counters and overflow; a negedge monitor compares whenever the DUT writes.
module tb_pcm_frame_packer;

    localparam int FL = 4;
`ifdef PCM_PACKER_FRAME_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk_wr = 1'b0;
    logic        rst_wr_n = 1'b0;
    logic        srst_wr_n = 1'b1;
    logic        enable = 1'b1;
    logic        sample_vld = 1'b0;
    logic        sample_sof = 1'b0;
    logic [15:0] sample_data = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int nwr = 0;

    // Reference model state
    bit          in_frame = 1'b0;
    bit          held = 1'b0;
    bit          ovf = 1'b0;
    logic [15:0] frames = '0;
    logic [15:0] drops = '0;
    logic [15:0] fq[$];
    logic [31:0] expq[$];

    pcm_frame_packer #(
        .SAMPLE_WIDTH (16),
        .FRAME_LEN    (FL),
        .CNT_WIDTH    (16)
    ) dut (
        .clk_wr       (clk_wr),
        .rst_wr_n     (rst_wr_n),
        .srst_wr_n    (srst_wr_n),
        .enable       (enable),
        .sample_vld   (sample_vld),
        .sample_sof   (sample_sof),
        .sample_data  (sample_data),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt),
        .overflow     (overflow)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_frame = 1'b0;
        held     = 1'b0;
        ovf      = 1'b0;
        frames   = '0;
        drops    = '0;
        fq.delete();
        expq.delete();
    endtask

    // Frame-level view: a frame is the list of samples so far; every even-sized list yields a word.
    task automatic model_step();
        bit          busy;
        bit          load;
        bit          drop;
        logic [31:0] w;
        busy = held & fifo_full;
        load = 1'b0;
        drop = 1'b0;
        w    = '0;
        if (!srst_wr_n) begin
            model_reset();
            return;
        end
        if (sample_vld) begin
            if (sample_sof && in_frame) begin
                drop     = 1'b1;
                in_frame = 1'b0;
            end
            if (sample_sof && enable) begin
                in_frame = 1'b1;
                fq.delete();
                fq.push_back(sample_data);
                if (HDR != 0) begin
                    if (busy) begin
                        drop     = 1'b1;
                        in_frame = 1'b0;
                    end else begin
                        load = 1'b1;
                        w    = {16'hA729, frames};
                    end
                end
            end else if (!sample_sof && in_frame) begin
                fq.push_back(sample_data);
                if (fq.size() % 2 == 0) begin
                    if (busy) begin
                        drop     = 1'b1;
                        in_frame = 1'b0;
                    end else begin
                        load = 1'b1;
                        w    = {fq[fq.size()-1], fq[fq.size()-2]};
                        if (fq.size() == FL) begin
                            frames++;
                            in_frame = 1'b0;
                        end
                    end
                end
            end
        end
        if (load) expq.push_back(w);
        held = load | (held & fifo_full);
        if (drop) drops++;
        ovf = drop;
    endtask

    always @(negedge clk_wr) begin
        logic [31:0] w;
        chk("wr_en", 32'(fifo_wr_en), 32'(held & ~fifo_full & srst_wr_n));
        chk("overflow", 32'(overflow), 32'(ovf));
        chk("frame_cnt", 32'(frame_cnt), 32'(frames));
        chk("drop_cnt", 32'(drop_cnt), 32'(drops));
        if (fifo_wr_en) begin
            nwr++;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_data: unexpected write %h, expected no write", fifo_wr_data);
            end else begin
                w = expq.pop_front();
                chk("wr_data", fifo_wr_data, w);
            end
        end
    end

    task automatic tick();
        @(posedge clk_wr);
        if (rst_wr_n) model_step();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [15:0] d, input bit sof, input int gap);
        sample_vld  = 1'b1;
        sample_sof  = sof;
        sample_data = d;
        tick();
        sample_vld  = 1'b0;
        sample_sof  = 1'b0;
        idle(gap);
    endtask

    task automatic do_reset();
        rst_wr_n = 1'b0;
        model_reset();
        nwr = 0;
        idle(2);
        rst_wr_n = 1'b1;
        idle(1);
    endtask

    task automatic send_frame(input logic [15:0] base);
        for (int i = 0; i < FL; i++) send(base + 16'(i), i == 0, 1);
    endtask

    initial begin
        bit sof;
        #1;
        chk("rst_wr_en", 32'(fifo_wr_en), 32'(0));
        chk("rst_wr_data", fifo_wr_data, 32'(0));
        chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        chk("rst_drop_cnt", 32'(drop_cnt), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        idle(2);
        rst_wr_n = 1'b1;
        idle(1);

        // Basic frame
        send(16'h1111, 1, 1);
        send(16'h2222, 0, 1);
        send(16'h3333, 0, 1);
        send(16'h4444, 0, 1);
        idle(4);
        chk("s1_frames", 32'(frame_cnt), 32'(1));
        chk("s1_drops", 32'(drop_cnt), 32'(0));
        chk("s1_writes", 32'(nwr), 32'(2 + HDR));

        // Back-pressure from first word to second word completion
        do_reset();
        send(16'h0101, 1, 1);
        sample_vld  = 1'b1;
        sample_data = 16'h0202;
        fifo_full   = 1'b1;
        tick();
        sample_vld = 1'b0;
        idle(1);
        send(16'h0303, 0, 1);
        send(16'h0404, 0, 1);
        idle(2);
        fifo_full = 1'b0;
        idle(3);
        chk("s3_writes_after_clear", 32'(nwr), 32'(1 + HDR));
        send_frame(16'h0a00);
        idle(4);
        chk("s3_frames", 32'(frame_cnt), 32'(1));
        chk("s3_drops", 32'(drop_cnt), 32'(1));
        chk("s3_writes", 32'(nwr), 32'(3 + 2 * HDR));

        // Early SOF on the third sample
        do_reset();
        send(16'h00a1, 1, 1);
        send(16'h00a2, 0, 1);
        send_frame(16'h0b00);
        idle(4);
        chk("s4_frames", 32'(frame_cnt), 32'(1));
        chk("s4_drops", 32'(drop_cnt), 32'(1));
        chk("s4_writes", 32'(nwr), 32'(3 + 2 * HDR));

        // Async reset after one sample
        do_reset();
        send(16'h00c1, 1, 1);
        do_reset();
        send_frame(16'h0c00);
        idle(4);
        chk("s5_frames", 32'(frame_cnt), 32'(1));
        chk("s5_drops", 32'(drop_cnt), 32'(0));
        chk("s5_writes", 32'(nwr), 32'(2 + HDR));

        // Disabled frame followed by an enabled one
        do_reset();
        enable = 1'b0;
        send_frame(16'h0d00);
        idle(2);
        chk("s6_disabled_writes", 32'(nwr), 32'(0));
        enable = 1'b1;
        send_frame(16'h0e00);
        idle(4);
        chk("s6_frames", 32'(frame_cnt), 32'(1));
        chk("s6_drops", 32'(drop_cnt), 32'(0));
        chk("s6_writes", 32'(nwr), 32'(2 + HDR));

        // Randomized traffic with back-pressure and occasional sync reset
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) fifo_full = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                srst_wr_n = 1'b0;
                tick();
                srst_wr_n = 1'b1;
            end
            if (!in_frame) begin
                enable = ($urandom_range(0, 5) != 0);
                sof    = ($urandom_range(0, 3) != 0);
            end else begin
                sof = ($urandom_range(0, 11) == 0);
            end
            send(16'($urandom), sof, $urandom_range(1, 3));
        end
        fifo_full = 1'b0;
        idle(4);
        chk("drain_empty", 32'(expq.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcm_frame_packer.md
# pcm_frame_packer

Write-domain front end of the G729 encoder sample path. It takes 16-bit PCM samples from the audio capture interface and packs sample pairs into 32-bit words. Words are written into the async FIFO's write port, and packing is aligned to 80-sample G729 frames. FIFO back-pressure is handled by dropping whole frames, never partial words, so the encoder never sees a split frame.

## Interface
- SAMPLE_WIDTH, 16, PCM sample width; the FIFO word is 2*SAMPLE_WIDTH.
- FRAME_LEN, 80, samples per frame; must be even and ≥ 2.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk_wr  in  1  write-domain clock.
- rst_wr_n  in  1  reset, asynchronous, active-low.
- srst_wr_n  in  1  synchronous active-low reset; same effect as rst_wr_n.
- enable  in  1  block enable; sampled only at frame start.
- sample_vld  in  1  one-cycle strobe, sample present.
- sample_sof  in  1  qualifies sample_vld; marks the first sample of a frame.
- sample_data  in  SAMPLE_WIDTH  PCM sample, two's complement.
- fifo_full  in  1  FIFO full flag from the write-side port.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  2*SAMPLE_WIDTH  FIFO write data.
- frame_cnt  out  CNT_WIDTH  frames fully delivered; wraps.
- drop_cnt  out  CNT_WIDTH  frames dropped or truncated; wraps.
- overflow  out  1  one-cycle pulse per drop event.

## Operation
- States:
  - WAIT_SOF: ignore samples until sample_vld & sample_sof & enable, then latch the sample as the low half, set idx=1, go to HI.
  - LO: the next sample becomes the low half; go to HI.
  - HI: the next sample completes word {sample_data, lo_reg}, with the first sample in [15:0]. Go to LO, or to WAIT_SOF when idx reaches FRAME_LEN-1; in that case frame_cnt increments.
  - DROP: ignore samples until a valid sample with sample_sof, then start a new frame as from WAIT_SOF. If enable is low at that point, go to WAIT_SOF instead.
- Output stage: a single word register, out_vld/out_data.
  - fifo_wr_en = out_vld & ~fifo_full.
  - out_vld clears on fifo_wr_en.
  - A load and a write in the same cycle are permitted.
- Overflow: a word completes while out_vld & fifo_full. The word is discarded, overflow pulses, drop_cnt increments, and the state goes to DROP.
- Early SOF in LO or HI: the partial frame is discarded, drop_cnt increments, overflow pulses, and the SOF sample starts a new frame. Words already written stay written.
- A sample with sample_sof in WAIT_SOF while enable=0 is ignored.
- fifo_wr_en is never asserted while fifo_full=1. The FIFO RAM write enable is ungated, so the block must guarantee this.
- idx counts samples 0..FRAME_LEN-1, with width clog2(FRAME_LEN).

## Timing
- Reset values:
  - state WAIT_SOF, out_vld 0.
  - fifo_wr_en 0, fifo_wr_data 0.
  - frame_cnt 0, drop_cnt 0, overflow 0.
- Latency: second sample of a pair accepted on cycle N → fifo_wr_en on N+1 if fifo_full=0.
- Input rate: at most one sample_vld every 2 cycles, so at most one word per 4 cycles.
- frame_cnt updates on the cycle after the last sample of a frame is accepted, even if that word is still held in the output stage.
- overflow and the drop_cnt update are registered and occur on the cycle after the offending sample.
- Reset mid-frame discards all partial state and the held word. No write is issued after reset asserts.

## Configuration
- PCM_PACKER_FRAME_HDR_EN:
  - Defined: on each accepted SOF, header word {16'hA729, frame_cnt[15:0]} loads into the output stage in the same cycle the first sample is latched. The header is subject to the same overflow rule; if it cannot load, the frame goes to DROP. Each frame is FRAME_LEN/2+1 words.
  - Undefined: no header; each frame is FRAME_LEN/2 words.

## Structure
- Package g729_pcm_pkg holds:
  - the state enum (WAIT_SOF, LO, HI, DROP);
  - HDR_MAGIC = 16'hA729;
  - the default FRAME_LEN.
- Sub-module pcm_word_stage: the single-entry output register with load/write handshake and a busy flag for overflow detection. The FSM and counters stay in the top module.

## Test plan
- FRAME_LEN=4, fifo_full=0, samples SOF 0x1111, then 0x2222, 0x3333, 0x4444 → writes 0x22221111, 0x44443333; frame_cnt=1; drop_cnt=0.
- Same stimulus with PCM_PACKER_FRAME_HDR_EN → writes 0xA7290000, 0x22221111, 0x44443333.
- fifo_full held from the first word until the second word completes → overflow pulse, drop_cnt=1, exactly one write after full clears, next SOF frame delivered intact.
- sample_sof on the 3rd sample of a FRAME_LEN=4 frame → drop_cnt=1, packing restarts on that sample, following full frame counted.
- rst_wr_n pulsed after one sample, then a full frame → no write from the partial pair; frame_cnt=1.
- enable=0 at SOF → no writes for that frame; enable=1 at the next SOF → normal delivery.
